alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Execute-to-memory pipeline stage directly downstream of the 32-bit ALU. It captures the ALU's low and high results and its C/Z/V flags for each issued operation, and holds the architectural flag register and the HI register for multiply upper words. It also carries the result toward the memory/writeback stage through a two-entry skid buffer with valid/ready handshakes, so downstream back-pressure never corrupts or drops an ALU result.

## Interface
Parameters:
- W, 32, datapath width (ALU result width)
- RDW, 5, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- flush  in  1  kill all buffered entries; the same-cycle input is discarded
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept; registered (= skid entry empty)
- in_sel  in  4  ALU opcode that produced the result (0 ADD … 15 NEG)
- in_out0  in  W  ALU low result
- in_out1  in  W  ALU high result (MUL upper word, else 0)
- in_c, in_z, in_v  in  1 each  ALU carry, zero and overflow flags
- in_setf  in  1  instruction architecturally writes flags
- in_rd  in  RDW  destination register index
- in_wen  in  1  destination write enable
- out_valid  out  1  buffered result available
- out_ready  in  1  downstream accepts
- out_data  out  W  result (low word)
- out_rd  out  RDW  destination index
- out_wen  out  1  destination write enable
- hi_q  out  W  HI register
- flags_q  out  3  {C,Z,V} flag register

## Operation
- Accept: acc = in_valid & in_ready & ~flush.
- Buffer: a main entry drives out_*, and a skid entry holds overflow. Each entry holds {data, rd, wen}. Order is strictly FIFO.
- Buffer moves on each edge (no flush):
  - main empty, acc: input goes to main.
  - main full, out_ready, skid empty, acc: input replaces main.
  - main full, out_ready, skid empty, no acc: main empties.
  - main full, ~out_ready, acc: input goes to skid (skid was empty, because in_ready = 1).
  - skid full, out_ready: skid moves to main and skid empties. No accept is possible this cycle (in_ready = 0).
  - skid full, ~out_ready: nothing moves.
- HI: on acc with in_sel = 2, hi_q <= in_out1. Any other opcode leaves hi_q unchanged.
- Flags: on acc with in_setf = 1, flags_q <= {in_c, in_z, in_v}. Otherwise flags_q holds.
- HI and flags commit at accept. A later flush does not roll them back.
- CMP (sel 14): in_out0 carries the comparison code 0/1/2 and is passed through unchanged. No other opcode gets special handling.
- Flush: on the next edge, both valid bits clear and the same-cycle input is dropped, with no HI/flags update. Stored data fields may hold stale values.
- Outputs whose valid is 0 are don't-care, except under reset (see Timing).

## Timing
- Reset (rst = 1 at edge) clears:
  - main and skid valid
  - out_data, out_rd, out_wen, hi_q, flags_q, all to 0
  - in_ready: 0 while rst is asserted, 1 on the first cycle after.
- Reset mid-operation discards all buffered entries. rst has priority over flush and acc.
- Latency: accept at edge N gives out_valid = 1 after edge N, provided main was empty or draining.
- Throughput: 1 result/cycle while out_ready = 1.
- Stall: out_data, out_rd and out_wen are stable while out_valid & ~out_ready. At most one extra result is absorbed, then in_ready falls on the following cycle.
- in_ready is a pure register output, with no combinational path from out_ready.
- hi_q and flags_q are visible the cycle after the accepting edge.
- Simultaneous flush and out_ready: the flush wins and no transfer is counted as delivered.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 -> out_valid = 0, hi_q = 0, flags_q = 3'b000, in_ready = 0. One cycle after release, in_ready = 1.
- Streaming: with out_ready = 1, send 4 ADD results 0x10..0x13 in back-to-back cycles, setf = 1, c = 0, z = 0, v = 1 -> out_data 0x10..0x13 appear on consecutive cycles, each one cycle after accept, and flags_q = 3'b001.
- MUL/HI: accept sel = 2, out0 = 0x00000000, out1 = 0x00000001, setf = 1, z = 1, c = 1, v = 0 -> hi_q = 0x00000001 and flags_q = 3'b110. Then a sel = 7 op with setf = 0 -> hi_q and flags unchanged.
- Back-pressure: out_ready = 0, accept A = 0xAAAA0000 then B = 0xBBBB0000 -> in_ready = 0 and out_data holds A. Raise out_ready -> A, then B, each delivered once in order, and in_ready returns to 1.
- Flush: with main and skid both full, assert flush together with in_valid (C = 0xCCCC, sel = 2, out1 = 5) -> next cycle out_valid = 0, C is never output, and hi_q is unchanged.
- Reset mid-stall: with both entries full and out_ready = 0, pulse rst -> out_valid = 0, hi_q = 0, flags_q = 0, and no stale result appears afterwards.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// ALU-to-memory result bus: ALU result/flags in, buffered writeback out,
// plus the architectural HI and flag registers.
interface alu_result_stage_if #(
   parameter int W   = 32,
   parameter int RDW = 5
);
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     in_sel;
   logic [W-1:0]   in_out0;
   logic [W-1:0]   in_out1;
   logic           in_c;
   logic           in_z;
   logic           in_v;
   logic           in_setf;
   logic [RDW-1:0] in_rd;
   logic           in_wen;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic [RDW-1:0] out_rd;
   logic           out_wen;
   logic [W-1:0]   hi_q;
   logic [2:0]     flags_q;

   modport master (
      output in_valid, in_sel, in_out0, in_out1,
      output in_c, in_z, in_v, in_setf, in_rd, in_wen,
      output out_ready,
      input  in_ready, out_valid, out_data, out_rd, out_wen,
      input  hi_q, flags_q
   );

   modport slave (
      input  in_valid, in_sel, in_out0, in_out1,
      input  in_c, in_z, in_v, in_setf, in_rd, in_wen,
      input  out_ready,
      output in_ready, out_valid, out_data, out_rd, out_wen,
      output hi_q, flags_q
   );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-memory stage: HI/flag registers plus a two-entry skid
// buffer carrying ALU results downstream.
module alu_result_stage #(
   parameter int W   = 32,
   parameter int RDW = 5
) (
   input logic              clk,
   input logic              rst,
   input logic              flush,
   alu_result_stage_if.slave bus
);
   typedef struct packed {
      logic [W-1:0]   data;
      logic [RDW-1:0] rd;
      logic           wen;
   } ent_t;

   localparam logic [3:0] SEL_MUL = 4'd2;

   ent_t       main_q;
   ent_t       skid_q;
   ent_t       in_ent;
   logic       main_v;
   logic       skid_v;
   logic       rdy_q;
   logic [W-1:0] hi;
   logic [2:0] flags;
   logic       acc;

   assign acc    = bus.in_valid & rdy_q & ~flush;
   assign in_ent = '{data: bus.in_out0,
                     rd:   bus.in_rd,
                     wen:  bus.in_wen};

   // in_ready tracks "skid will be empty", so it never sees out_ready combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b1;
      end else if (skid_v) begin
         if (bus.out_ready) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
         end
         rdy_q <= bus.out_ready;
      end else if (!main_v) begin
         if (acc) begin
            main_q <= in_ent;
            main_v <= 1'b1;
         end
         rdy_q <= 1'b1;
      end else if (bus.out_ready) begin
         if (acc) main_q <= in_ent;
         else     main_v <= 1'b0;
         rdy_q <= 1'b1;
      end else begin
         if (acc) begin
            skid_q <= in_ent;
            skid_v <= 1'b1;
         end
         rdy_q <= ~acc;
      end
   end

   // HI and flags commit at accept; a later flush does not undo them
   always_ff @(posedge clk) begin
      if (rst) begin
         hi    <= '0;
         flags <= '0;
      end else begin
         if (acc && bus.in_sel == SEL_MUL) hi <= bus.in_out1;
         if (acc && bus.in_setf) flags <= {bus.in_c, bus.in_z, bus.in_v};
      end
   end

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = main_v;
   assign bus.out_data  = main_q.data;
   assign bus.out_rd    = main_q.rd;
   assign bus.out_wen   = main_q.wen;
   assign bus.hi_q      = hi;
   assign bus.flags_q   = flags;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and random checks of alu_result_stage against a FIFO-queue
// reference model.
module tb_alu_result_stage;
   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   failures;

   alu_result_stage_if #(.W(32), .RDW(5)) bus ();

   alu_result_stage #(.W(32), .RDW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  rd;
      logic        wen;
   } me_t;

   me_t         q[$];
   logic [31:0] m_hi;
   logic [2:0]  m_fl;
   logic        m_rdy;
   bit          m_rst;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: a queue of at most two results, popped on a handshake
   task automatic model_edge();
      bit acc;
      acc = bus.in_valid && m_rdy && !flush;
      if (rst) begin
         q.delete();
         m_hi  = '0;
         m_fl  = '0;
         m_rdy = 1'b0;
         m_rst = 1'b1;
      end else begin
         m_rst = 1'b0;
         if (acc && bus.in_sel == 4'd2) m_hi = bus.in_out1;
         if (acc && bus.in_setf) m_fl = {bus.in_c, bus.in_z, bus.in_v};
         if (flush) q.delete();
         else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (acc) q.push_back('{d: bus.in_out0, rd: bus.in_rd, wen: bus.in_wen});
         end
         m_rdy = (q.size() < 2);
      end
   endtask

   task automatic model_check();
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
      chk("out_valid", {31'd0, bus.out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
      if (q.size() > 0) begin
         chk("out_data", bus.out_data, q[0].d);
         chk("out_rd", {27'd0, bus.out_rd}, {27'd0, q[0].rd});
         chk("out_wen", {31'd0, bus.out_wen}, {31'd0, q[0].wen});
      end
      if (m_rst) begin
         chk("rst_data", bus.out_data, 32'd0);
         chk("rst_rd", {27'd0, bus.out_rd}, 32'd0);
         chk("rst_wen", {31'd0, bus.out_wen}, 32'd0);
      end
      chk("hi_q", bus.hi_q, m_hi);
      chk("flags_q", {29'd0, bus.flags_q}, {29'd0, m_fl});
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic put(logic [31:0] d, logic [3:0] sel, logic [31:0] o1,
                      logic c, logic z, logic v, logic setf);
      bus.in_valid = 1'b1;
      bus.in_out0  = d;
      bus.in_sel   = sel;
      bus.in_out1  = o1;
      bus.in_c     = c;
      bus.in_z     = z;
      bus.in_v     = v;
      bus.in_setf  = setf;
      bus.in_rd    = 5'($urandom);
      bus.in_wen   = 1'($urandom);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      clk = 1'b0;
      rst = 1'b1;
      flush = 1'b0;
      m_rdy = 1'b0;
      m_hi = '0;
      m_fl = '0;
      m_rst = 1'b0;
      bus.out_ready = 1'b0;
      put(32'h1234, 4'd2, 32'hdead, 1'b1, 1'b1, 1'b1, 1'b1);

      // reset held two cycles with in_valid high
      cycle();
      cycle();
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_hi", bus.hi_q, 32'd0);
      chk("rst_flags", {29'd0, bus.flags_q}, 32'd0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      cycle();
      chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // streaming ADDs
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         put(32'h10 + 32'(i), 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
         cycle();
         chk("stream_data", bus.out_data, 32'h10 + 32'(i));
         chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      bus.in_valid = 1'b0;
      cycle();
      chk("stream_flags", {29'd0, bus.flags_q}, 32'b001);

      // MUL writes HI and flags, then a non-flag op leaves both
      put(32'd0, 4'd2, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle();
      chk("mul_hi", bus.hi_q, 32'd1);
      chk("mul_flags", {29'd0, bus.flags_q}, 32'b110);
      put(32'h77, 4'd7, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      chk("op7_hi", bus.hi_q, 32'd1);
      chk("op7_flags", {29'd0, bus.flags_q}, 32'b110);
      bus.in_valid = 1'b0;
      cycle();

      // back-pressure
      bus.out_ready = 1'b0;
      put(32'hAAAA0000, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      put(32'hBBBB0000, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.in_valid = 1'b0;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_a", bus.out_data, 32'hAAAA0000);
      cycle();
      chk("bp_hold_a2", bus.out_data, 32'hAAAA0000);
      bus.out_ready = 1'b1;
      cycle();
      chk("bp_b", bus.out_data, 32'hBBBB0000);
      chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
      cycle();
      chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

      // flush with both entries full
      bus.out_ready = 1'b0;
      put(32'h1, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      put(32'h2, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      flush = 1'b1;
      put(32'hCCCC, 4'd2, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_hi", bus.hi_q, 32'd1);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("flush_no_c", {31'd0, bus.out_valid}, 32'd0);
      end

      // reset mid-stall
      bus.out_ready = 1'b0;
      put(32'h3, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      put(32'h4, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      cycle();
      chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mrst_hi", bus.hi_q, 32'd0);
      chk("mrst_flags", {29'd0, bus.flags_q}, 32'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("mrst_no_stale", {31'd0, bus.out_valid}, 32'd0);
      end

      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         put($urandom, 4'($urandom), $urandom, 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
         bus.in_valid  = ($urandom_range(3) != 0);
         bus.out_ready = ($urandom_range(2) != 0);
         flush = ($urandom_range(15) == 0);
         rst   = ($urandom_range(63) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
